hwpe_top_wrap_pipe: RTL and testbench

HWPE_TOP_WRAP_PIPE -- requirements
Module: hwpe_top_wrap_pipe

---
 rtl/hwpe_wrap_pipe_package.sv | 30 +++
 rtl/hwpe_tcdm_req_slice.sv | 87 ++++++++
 rtl/hwpe_top.sv | 115 +++++++++++
 rtl/hwpe_top_wrap_pipe.sv | 71 +++++++
 tb/tb_hwpe_top_wrap_pipe.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_wrap_pipe_package.sv
// Shared TCDM request payload, bus widths and peripheral register map for the pipelined HWPE wrapper.
package hwpe_wrap_pipe_package;

  localparam int unsigned TCDM_AW       = 32;
  localparam int unsigned TCDM_DW       = 32;
  localparam int unsigned TCDM_BEW      = TCDM_DW / 8;
  localparam int unsigned REGFILE_N_EVT = 2;

  typedef struct packed {
    logic [TCDM_AW-1:0]  add;
    logic                wen;
    logic [TCDM_BEW-1:0] be;
    logic [TCDM_DW-1:0]  data;
  } tcdm_req_t;

  localparam logic [31:0] REG_BASE    = 32'h00;
  localparam logic [31:0] REG_COUNT   = 32'h04;
  localparam logic [31:0] REG_CTRL    = 32'h08;
  localparam logic [31:0] REG_SEED    = 32'h0C;
  localparam logic [31:0] REG_TRIGGER = 32'h10;
  localparam logic [31:0] REG_RDATA   = 32'h14;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/hwpe_tcdm_req_slice.sv
// Per-port TCDM request stage: optional 2-entry skid buffer plus read-response credit limiter.
// One cycle latency when buffered (zero otherwise); requests held while credits are exhausted.
module hwpe_tcdm_req_slice
  import hwpe_wrap_pipe_package::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          SLICE_EN        = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_req,
  output logic      in_gnt,
  input  tcdm_req_t in_pl,
  output logic      out_req,
  input  logic      out_gnt,
  output tcdm_req_t out_pl,
  input  logic      r_valid,
  input  logic      err_clr,
  output logic      err,
  output logic      busy
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] credit_q;
  logic          credit_ok, rd_issue, rsp_take;

  // a response landing this cycle frees the slot the new read will take
  assign credit_ok = (credit_q != CW'(MAX_OUTSTANDING)) || r_valid;
  assign rd_issue  = out_req && out_gnt && out_pl.wen;
  assign rsp_take  = r_valid && (credit_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
      err      <= 1'b0;
    end else begin
      if (rd_issue && !rsp_take)      credit_q <= credit_q + CW'(1);
      else if (!rd_issue && rsp_take) credit_q <= credit_q - CW'(1);
      if (err_clr)                             err <= 1'b0;
      else if (r_valid && credit_q == '0)      err <= 1'b1;
    end
  end

  if (SLICE_EN) begin : g_skid
    logic [1:0] cnt_q;
    tcdm_req_t  head_q, tail_q;
    logic       push, pop;

    assign in_gnt  = cnt_q < 2'd2;
    assign out_req = (cnt_q != 2'd0) && credit_ok;
    assign out_pl  = head_q;
    assign push    = in_req && in_gnt;
    assign pop     = out_req && out_gnt;
    assign busy    = (cnt_q != 2'd0) || (credit_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        head_q <= '0;
        tail_q <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (cnt_q == 2'd0) head_q <= in_pl;
            else               tail_q <= in_pl;
            cnt_q <= cnt_q + 2'd1;
          end
          2'b01: begin
            head_q <= tail_q;
            tail_q <= '0;
            cnt_q  <= cnt_q - 2'd1;
          end
          // only reachable with one entry, since a full buffer withholds in_gnt
          2'b11:   head_q <= in_pl;
          default: ;
        endcase
      end
    end
  end else begin : g_pass
    assign out_req = in_req && credit_ok;
    assign in_gnt  = out_gnt && credit_ok;
    assign out_pl  = in_pl;
    assign busy    = credit_q != '0;
  end

endmodule

// File: rtl/hwpe_top.sv
// Streaming engine: peripheral register file configures a job of COUNT accesses on one TCDM port.
// Peripheral is always granted and answers one cycle later; the job stalls on per-port grant.
module hwpe_top
  import hwpe_wrap_pipe_package::*;
#(
  parameter int unsigned N_CORES       = 2,
  parameter int unsigned ID_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_TCDM_PORTS = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  output logic [N_CORES-1:0][REGFILE_N_EVT-1:0]    evt,
  output logic [NB_TCDM_PORTS-1:0]                 tcdm_req,
  input  logic [NB_TCDM_PORTS-1:0]                 tcdm_gnt,
  output tcdm_req_t                                tcdm_pl,
  input  logic [NB_TCDM_PORTS-1:0][TCDM_DW-1:0]    tcdm_r_data,
  input  logic [NB_TCDM_PORTS-1:0]                 tcdm_r_valid,
  input  logic                                     periph_req,
  output logic                                     periph_gnt,
  input  logic [31:0]                              periph_add,
  input  logic                                     periph_wen,
  input  logic [3:0]                               periph_be,
  input  logic [DATA_WIDTH-1:0]                    periph_data,
  input  logic [ID_WIDTH-1:0]                      periph_id,
  output logic [DATA_WIDTH-1:0]                    periph_r_data,
  output logic                                     periph_r_valid,
  output logic [ID_WIDTH-1:0]                      periph_r_id
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] base_q, count_q, seed_q, rdata_q, job_q;
  logic [4:0]  ctrl_q;
  logic [31:0] wdata, rd_mux, rsp_data;
  logic        granted, wr_hit;

  assign periph_gnt = 1'b1;
  assign wdata      = 32'(periph_data);
  assign wr_hit     = periph_req && !periph_wen;
  assign granted    = |(tcdm_req & tcdm_gnt);

  // ctrl_q[3:0] selects the port, ctrl_q[4] marks the job as reads
  assign tcdm_req     = (state == RUN) ? (NB_TCDM_PORTS'(1) << ctrl_q[3:0]) : '0;
  assign tcdm_pl.add  = base_q + (job_q << 2);
  assign tcdm_pl.wen  = ctrl_q[4];
  assign tcdm_pl.be   = '1;
  assign tcdm_pl.data = seed_q + job_q;

  always_comb begin
    rsp_data = '0;
    for (int p = 0; p < NB_TCDM_PORTS; p++) if (tcdm_r_valid[p]) rsp_data = rsp_data | tcdm_r_data[p];
  end

  always_comb begin
    rd_mux = '0;
    case (periph_add)
      REG_BASE:    rd_mux = base_q;
      REG_COUNT:   rd_mux = count_q;
      REG_CTRL:    rd_mux = {27'b0, ctrl_q};
      REG_SEED:    rd_mux = seed_q;
      REG_TRIGGER: rd_mux = {31'b0, state == RUN};
      REG_RDATA:   rd_mux = rdata_q;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      base_q         <= '0;
      count_q        <= '0;
      ctrl_q         <= '0;
      seed_q         <= '0;
      rdata_q        <= '0;
      job_q          <= '0;
      evt            <= '0;
      periph_r_valid <= 1'b0;
      periph_r_id    <= '0;
      periph_r_data  <= '0;
    end else begin
      periph_r_valid <= periph_req;
      periph_r_id    <= periph_id;
      periph_r_data  <= DATA_WIDTH'(periph_wen ? rd_mux : 32'h0);
      evt            <= '0;
      if (|tcdm_r_valid) rdata_q <= rsp_data;
      if (wr_hit) begin
        case (periph_add)
          REG_BASE:  base_q  <= be_merge(base_q, wdata, periph_be);
          REG_COUNT: count_q <= be_merge(count_q, wdata, periph_be);
          REG_CTRL:  ctrl_q  <= wdata[4:0];
          REG_SEED:  seed_q  <= be_merge(seed_q, wdata, periph_be);
          default:   ;
        endcase
      end
      case (state)
        IDLE: if (wr_hit && periph_add == REG_TRIGGER && count_q != '0) begin
          state <= RUN;
          job_q <= '0;
        end
        RUN: if (granted) begin
          if (job_q == count_q - 32'd1) begin
            state <= IDLE;
            evt   <= {N_CORES{REGFILE_N_EVT'(1)}};
          end else begin
            job_q <= job_q + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hwpe_top_wrap_pipe.sv
// HWPE wrapper: engine peripheral mapped straight through, each TCDM port behind a request slice.
// Requests see one cycle of latency with SLICE_EN=1; TCDM backpressure and credits stall the engine.
module hwpe_top_wrap_pipe
  import hwpe_wrap_pipe_package::*;
#(
  parameter int unsigned N_CORES         = 2,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NB_TCDM_PORTS   = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          SLICE_EN        = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  output logic [N_CORES-1:0][REGFILE_N_EVT-1:0] evt,
  output logic [NB_TCDM_PORTS-1:0]              tcdm_req,
  input  logic [NB_TCDM_PORTS-1:0]              tcdm_gnt,
  output logic [NB_TCDM_PORTS-1:0][31:0]        tcdm_add,
  output logic [NB_TCDM_PORTS-1:0]              tcdm_wen,
  output logic [NB_TCDM_PORTS-1:0][3:0]         tcdm_be,
  output logic [NB_TCDM_PORTS-1:0][31:0]        tcdm_data,
  input  logic [NB_TCDM_PORTS-1:0][31:0]        tcdm_r_data,
  input  logic [NB_TCDM_PORTS-1:0]              tcdm_r_valid,
  input  logic                                  periph_req,
  output logic                                  periph_gnt,
  input  logic [31:0]                           periph_add,
  input  logic                                  periph_wen,
  input  logic [3:0]                            periph_be,
  input  logic [DATA_WIDTH-1:0]                 periph_data,
  input  logic [ID_WIDTH-1:0]                   periph_id,
  output logic [DATA_WIDTH-1:0]                 periph_r_data,
  output logic                                  periph_r_valid,
  output logic [ID_WIDTH-1:0]                   periph_r_id,
  output logic                                  busy,
  output logic [NB_TCDM_PORTS-1:0]              err_unexp_rvalid,
  input  logic                                  err_clr
);

  logic [NB_TCDM_PORTS-1:0] int_req, int_gnt, slice_busy;
  tcdm_req_t                int_pl;
  tcdm_req_t [NB_TCDM_PORTS-1:0] out_pl;

  hwpe_top #(
    .N_CORES(N_CORES), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NB_TCDM_PORTS(NB_TCDM_PORTS)
  ) u_engine (
    .clk(clk), .rst_n(rst_n), .evt(evt),
    .tcdm_req(int_req), .tcdm_gnt(int_gnt), .tcdm_pl(int_pl),
    .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid),
    .periph_req(periph_req), .periph_gnt(periph_gnt), .periph_add(periph_add),
    .periph_wen(periph_wen), .periph_be(periph_be), .periph_data(periph_data),
    .periph_id(periph_id), .periph_r_data(periph_r_data), .periph_r_valid(periph_r_valid),
    .periph_r_id(periph_r_id)
  );

  for (genvar i = 0; i < NB_TCDM_PORTS; i++) begin : g_port
    hwpe_tcdm_req_slice #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .SLICE_EN(SLICE_EN)) u_slice (
      .clk(clk), .rst_n(rst_n),
      .in_req(int_req[i]), .in_gnt(int_gnt[i]), .in_pl(int_pl),
      .out_req(tcdm_req[i]), .out_gnt(tcdm_gnt[i]), .out_pl(out_pl[i]),
      .r_valid(tcdm_r_valid[i]), .err_clr(err_clr), .err(err_unexp_rvalid[i]),
      .busy(slice_busy[i])
    );
    assign tcdm_add[i]  = out_pl[i].add;
    assign tcdm_wen[i]  = out_pl[i].wen;
    assign tcdm_be[i]   = out_pl[i].be;
    assign tcdm_data[i] = out_pl[i].data;
  end

  assign busy = |slice_busy;

endmodule

// File: tb/tb_hwpe_top_wrap_pipe.sv
// Scoreboard bench for hwpe_top_wrap_pipe: directed engine jobs, TCDM and peripheral responses checked by a monitor.
module tb_hwpe_top_wrap_pipe;
  import hwpe_wrap_pipe_package::*;

  localparam int NB = 4;
  localparam int NC = 2;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic [NC-1:0][REGFILE_N_EVT-1:0] evt;
  logic [NB-1:0]                  tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
  logic [NB-1:0][31:0]            tcdm_add, tcdm_data, tcdm_r_data;
  logic [NB-1:0][3:0]             tcdm_be;
  logic                           periph_req, periph_gnt, periph_wen, periph_r_valid;
  logic [31:0]                    periph_add, periph_data, periph_r_data;
  logic [3:0]                     periph_be;
  logic [15:0]                    periph_id, periph_r_id;
  logic                           busy, err_clr;
  logic [NB-1:0]                  err_unexp_rvalid;

  always #5 clk = ~clk;

  hwpe_top_wrap_pipe #(
    .N_CORES(NC), .ID_WIDTH(16), .DATA_WIDTH(32), .NB_TCDM_PORTS(NB), .MAX_OUTSTANDING(4), .SLICE_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .evt(evt),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid),
    .periph_req(periph_req), .periph_gnt(periph_gnt), .periph_add(periph_add), .periph_wen(periph_wen),
    .periph_be(periph_be), .periph_data(periph_data), .periph_id(periph_id),
    .periph_r_data(periph_r_data), .periph_r_valid(periph_r_valid), .periph_r_id(periph_r_id),
    .busy(busy), .err_unexp_rvalid(err_unexp_rvalid), .err_clr(err_clr)
  );

  typedef struct { int port; logic [31:0] add; logic wen; logic [31:0] data; } txn_t;
  typedef struct { logic [15:0] id; logic [31:0] data; } rsp_t;

  txn_t exp_q[$];
  rsp_t rsp_q[$];
  int   total = 0, bad = 0;
  int   gnt_cnt[NB];
  int   evt_cnt = 0;
  logic [15:0] id_ctr = 16'h0100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  txn_t mt;
  rsp_t mr;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < NB; p++) begin
        if (tcdm_req[p] && tcdm_gnt[p]) begin
          gnt_cnt[p]++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tcdm_extra: port %0d add %0h granted, expected no request", p, tcdm_add[p]);
          end else begin
            mt = exp_q.pop_front();
            check("tcdm_port", 64'(p), 64'(mt.port));
            check("tcdm_add", tcdm_add[p], mt.add);
            check("tcdm_wen", tcdm_wen[p], mt.wen);
            check("tcdm_be", tcdm_be[p], 4'hF);
            if (!mt.wen) check("tcdm_data", tcdm_data[p], mt.data);
          end
        end
      end
      if (periph_r_valid) begin
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL periph_extra: r_data %0h id %0h, expected no response", periph_r_data, periph_r_id);
        end else begin
          mr = rsp_q.pop_front();
          check("periph_r_id", periph_r_id, mr.id);
          check("periph_r_data", periph_r_data, mr.data);
        end
      end
      if (evt[0][0] && evt[1][0]) evt_cnt++;
    end
  end

  task automatic preg(input logic [31:0] add, input logic wen, input logic [31:0] data,
                      input logic [3:0] be, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    periph_req = 1'b1; periph_add = add; periph_wen = wen;
    periph_data = data; periph_be = be; periph_id = id_ctr;
    rsp_q.push_back('{id_ctr, wen ? exp_rd : 32'h0});
    id_ctr = id_ctr + 16'h1;
    @(posedge clk); #1;
    periph_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] add, input logic [31:0] data);
    preg(add, 1'b0, data, 4'hF, 32'h0);
  endtask

  task automatic expect_job(input int port, input logic [31:0] base, input int cnt,
                            input logic rd, input logic [31:0] seed);
    for (int k = 0; k < cnt; k++) exp_q.push_back('{port, base + 32'(4*k), rd, seed + 32'(k)});
  endtask

  task automatic start_job(input int port, input logic [31:0] base, input int cnt,
                           input logic rd, input logic [31:0] seed);
    wr(REG_BASE, base);
    wr(REG_COUNT, 32'(cnt));
    wr(REG_CTRL, {27'b0, rd, 4'(port)});
    wr(REG_SEED, seed);
    wr(REG_TRIGGER, 32'h1);
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin @(posedge clk); n++; end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rvalid_pulse(input int port, input logic [31:0] data, input logic clr);
    @(posedge clk); #1;
    tcdm_r_valid[port] = 1'b1; tcdm_r_data[port] = data; err_clr = clr;
    @(posedge clk); #1;
    tcdm_r_valid = '0; err_clr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    tcdm_gnt = '0; tcdm_r_valid = '0; tcdm_r_data = '0; err_clr = 1'b0;
    periph_req = 1'b0; periph_add = '0; periph_wen = 1'b0; periph_be = '0;
    periph_data = '0; periph_id = '0;
    for (int p = 0; p < NB; p++) gnt_cnt[p] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tcdm_req", tcdm_req, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_unexp_rvalid, 4'h0);
    check("rst_periph_r_valid", periph_r_valid, 1'b0);
    check("rst_evt", evt, 4'h0);
    rst_n = 1'b1;
    tcdm_gnt = '1;

    // back-to-back writes on port 0
    expect_job(0, 32'h1000, 8, 1'b0, 32'hA0);
    start_job(0, 32'h1000, 8, 1'b0, 32'hA0);
    @(negedge clk); check("b2b_first_cycle_req", tcdm_req[0], 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); check("b2b_stream_req", tcdm_req[0], 1'b1);
    end
    @(negedge clk); check("b2b_after_req", tcdm_req[0], 1'b0);
    drain("b2b_drain", 20);
    check("b2b_gnt_cnt", 64'(gnt_cnt[0]), 64'd8);
    check("b2b_evt_cnt", 64'(evt_cnt), 64'd1);

    // backpressure on port 1
    tcdm_gnt[1] = 1'b0;
    expect_job(1, 32'h2000, 4, 1'b0, 32'h50);
    start_job(1, 32'h2000, 4, 1'b0, 32'h50);
    @(negedge clk); check("bp_int_gnt_c0", dut.int_gnt[1], 1'b1);
    @(negedge clk); check("bp_int_gnt_c1", dut.int_gnt[1], 1'b1);
    check("bp_req_c1", tcdm_req[1], 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_int_gnt_full", dut.int_gnt[1], 1'b0);
      check("bp_req_held", tcdm_req[1], 1'b1);
      check("bp_head_add", tcdm_add[1], 32'h2000);
      check("bp_head_data", tcdm_data[1], 32'h50);
      check("bp_busy", busy, 1'b1);
    end
    @(posedge clk); #1; tcdm_gnt[1] = 1'b1;
    drain("bp_drain", 20);
    check("bp_gnt_cnt", 64'(gnt_cnt[1]), 64'd4);

    // credit limit on port 3: six reads, responses withheld
    expect_job(3, 32'h3000, 6, 1'b1, 32'h0);
    start_job(3, 32'h3000, 6, 1'b1, 32'h0);
    repeat (12) @(negedge clk);
    check("cr_req_held", tcdm_req[3], 1'b0);
    check("cr_granted4", 64'(gnt_cnt[3]), 64'd4);
    check("cr_busy", busy, 1'b1);
    @(posedge clk); #1; tcdm_r_valid[3] = 1'b1; tcdm_r_data[3] = 32'hD000;
    @(negedge clk); check("cr_same_cycle_req", tcdm_req[3], 1'b1);
    @(posedge clk); #1; tcdm_r_valid = '0;
    @(negedge clk);
    check("cr_granted5", 64'(gnt_cnt[3]), 64'd5);
    check("cr_req_held_again", tcdm_req[3], 1'b0);
    for (int k = 1; k <= 5; k++) rvalid_pulse(3, 32'hD000 + 32'(k), 1'b0);
    @(negedge clk);
    check("cr_granted6", 64'(gnt_cnt[3]), 64'd6);
    check("cr_idle_busy", busy, 1'b0);
    check("cr_no_err", err_unexp_rvalid, 4'h0);
    drain("cr_drain", 5);
    preg(REG_RDATA, 1'b1, 32'h0, 4'hF, 32'h0000D005);

    // peripheral pass-through with byte enables
    wr(REG_SEED, 32'h12345678);
    preg(REG_SEED, 1'b1, 32'h0, 4'hF, 32'h12345678);
    preg(REG_SEED, 1'b0, 32'hAABBCCDD, 4'b0011, 32'h0);
    preg(REG_SEED, 1'b1, 32'h0, 4'hF, 32'h1234CCDD);
    preg(REG_CTRL, 1'b1, 32'h0, 4'hF, 32'h00000013);

    // unexpected response on port 2
    rvalid_pulse(2, 32'h0BAD, 1'b0);
    check("unexp_set", err_unexp_rvalid, 4'b0100);
    check("unexp_busy", busy, 1'b0);
    rvalid_pulse(2, 32'h0BAD, 1'b1);
    check("unexp_clr_priority", err_unexp_rvalid, 4'b0000);
    rvalid_pulse(2, 32'h0BAD, 1'b0);
    check("unexp_set_again", err_unexp_rvalid, 4'b0100);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    check("unexp_clr", err_unexp_rvalid, 4'b0000);

    // reset mid-operation: 3 reads outstanding and 2 buffered on port 0
    g0 = gnt_cnt[0];
    expect_job(0, 32'h4000, 8, 1'b1, 32'h0);
    start_job(0, 32'h4000, 8, 1'b1, 32'h0);
    repeat (4) @(posedge clk);
    #1; tcdm_gnt[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("rm_granted3", 64'(gnt_cnt[0] - g0), 64'd3);
    check("rm_req_pending", tcdm_req[0], 1'b1);
    check("rm_full", dut.int_gnt[0], 1'b0);
    check("rm_busy", busy, 1'b1);
    #2; rst_n = 1'b0;
    #1;
    check("rm_async_req", tcdm_req, 4'h0);
    check("rm_async_busy", busy, 1'b0);
    exp_q.delete();
    g0 = gnt_cnt[0];
    @(posedge clk); #1;
    rst_n = 1'b1; tcdm_gnt = '1;
    repeat (10) @(negedge clk);
    check("rm_no_replay", 64'(gnt_cnt[0] - g0), 64'd0);
    check("rm_idle_req", tcdm_req, 4'h0);
    check("rm_idle_busy", busy, 1'b0);

    repeat (2) @(negedge clk);
    check("end_rsp_q", 64'(rsp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
